// File: rtl/fpu_sp_pkg.sv
// Shared types and constants for the single-precision divide controller.
package fpu_sp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    ZERO = 2'd0,
    NORM = 2'd1,
    INF  = 2'd2,
    NAN  = 2'd3
  } op_class_e;

  localparam logic [31:0] QNAN     = 32'h7FC0_0000;
  localparam logic [7:0]  EXP_ONES = 8'hFF;

  // Bit positions inside flags = {nv, dz, of, uf}
  localparam int FLAG_NV = 3;
  localparam int FLAG_DZ = 2;
  localparam int FLAG_OF = 1;
  localparam int FLAG_UF = 0;

  // Denormals (exponent 0) are treated as zero.
  function automatic op_class_e classify(input logic [31:0] x);
    if (x[30:23] == 8'h00)          return ZERO;
    else if (x[30:23] != EXP_ONES)  return NORM;
    else if (x[22:0] == 23'd0)      return INF;
    else                            return NAN;
  endfunction

endpackage

// File: rtl/fpu_sp_divider.sv
// Combinational divide of two normal single-precision operands.
// Round-to-nearest-even; exponent overflow saturates to inf, underflow flushes to zero.
module fpu_sp_divider (
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient
);

  logic [23:0]        man_a, man_b;
  logic [49:0]        num, den, q_full, r_full;
  logic [26:0]        q;
  logic [23:0]        man;
  logic               guard, sticky, round_up, sgn;
  logic [24:0]        man_r;
  logic signed [9:0]  exp_r;
  logic               unused_bits;

  assign man_a  = {1'b1, dividend[22:0]};
  assign man_b  = {1'b1, divisor[22:0]};
  // Two extra quotient bits beyond the 24-bit mantissa give guard plus one sticky bit.
  assign num    = {man_a, 26'd0};
  assign den    = {26'd0, man_b};
  assign q_full = num / den;
  assign r_full = num % den;
  assign q      = q_full[26:0];
  assign sgn    = dividend[31] ^ divisor[31];
  assign unused_bits = ^{q_full[49:27], man_r[23]};

  // Normalise, round, and range-limit the quotient.
  always_comb begin
    if (q[26]) begin
      man    = q[26:3];
      guard  = q[2];
      sticky = (|q[1:0]) | (|r_full);
    end else begin
      man    = q[25:2];
      guard  = q[1];
      sticky = q[0] | (|r_full);
    end
    round_up = guard & (sticky | man[0]);
    man_r    = {1'b0, man} + {24'd0, round_up};
    // A rounding carry leaves the fraction at zero and bumps the exponent.
    exp_r    = $signed({2'b00, dividend[30:23]}) - $signed({2'b00, divisor[30:23]})
             + 10'sd126 + $signed({9'd0, q[26]}) + $signed({9'd0, man_r[24]});
    if (exp_r >= 10'sd255)
      quotient = {sgn, 8'hFF, 23'd0};
    else if (exp_r <= 10'sd0)
      quotient = {sgn, 31'd0};
    else
      quotient = {sgn, exp_r[7:0], man_r[22:0]};
  end

endmodule

// File: rtl/fpu_sp_div_ctrl.sv
// Handshake controller around the single-precision divider.
//   state | meaning
//   IDLE  | in_ready high, waiting for an operand pair
//   WAIT  | divider settling on registered operands, counter running
//   DONE  | result registered on first cycle, held until out_ready
module fpu_sp_div_ctrl
  import fpu_sp_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic [3:0]  flags
);

  localparam logic [3:0] CNT_LOAD = 4'(DIV_CYCLES);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic [31:0] result_q, result_d;
  logic [3:0]  flags_q, flags_d;
  logic        out_valid_q, out_valid_d;

  logic [31:0] quotient;
  op_class_e   cls_a, cls_b;
  logic        special, sgn;
  logic [31:0] spec_res;
  logic [3:0]  spec_flg;

  fpu_sp_divider u_divider (
    .dividend (op_a_q),
    .divisor  (op_b_q),
    .quotient (quotient)
  );

  assign cls_a     = classify(op_a_q);
  assign cls_b     = classify(op_b_q);
  assign special   = !(cls_a == NORM && cls_b == NORM);
  assign sgn       = op_a_q[31] ^ op_b_q[31];
  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;

  // Special-operand result table; inf/0 deliberately yields inf without dz.
  always_comb begin
    spec_res = {sgn, 31'd0};
    spec_flg = 4'b0000;
    if (cls_a == NAN || cls_b == NAN || (cls_a == ZERO && cls_b == ZERO) ||
        (cls_a == INF && cls_b == INF)) begin
      spec_res          = QNAN;
      spec_flg[FLAG_NV] = 1'b1;
    end else if (cls_a == INF) begin
      spec_res = {sgn, EXP_ONES, 23'd0};
    end else if (cls_b == ZERO) begin
      spec_res          = {sgn, EXP_ONES, 23'd0};
      spec_flg[FLAG_DZ] = 1'b1;
    end
  end

  // Next-state and datapath register inputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    result_d    = result_q;
    flags_d     = flags_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_a_d = a;
          op_b_d = b;
          if (classify(a) == NORM && classify(b) == NORM) begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end else begin
            state_d = DONE;
          end
        end
      end
      WAIT: begin
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          if (special) begin
            result_d = spec_res;
            flags_d  = spec_flg;
          end else begin
            flags_d          = 4'b0000;
            flags_d[FLAG_OF] = (quotient[30:23] == EXP_ONES);
            flags_d[FLAG_UF] = (quotient[30:23] == 8'h00);
            result_d = (quotient[30:23] == 8'h00) ? {quotient[31], 31'd0} : quotient;
          end
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      op_a_q      <= 32'd0;
      op_b_q      <= 32'd0;
      result_q    <= 32'd0;
      flags_q     <= 4'd0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_fpu_sp_div_ctrl.sv
// Scoreboard bench for fpu_sp_div_ctrl with DIV_CYCLES = 2.
module tb_fpu_sp_div_ctrl;

  localparam int DIVC = 2;
  localparam int LAT_N = DIVC + 1;
  localparam int LAT_S = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        in_ready, out_valid;
  logic [31:0] result;
  logic [3:0]  flags;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flg;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;

  fpu_sp_div_ctrl #(.DIV_CYCLES(DIVC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  // Drive an operand pair, push its expectation, return just after the transfer edge.
  task automatic push_op(input logic [31:0] ta, input logic [31:0] tb_v,
                         input logic [31:0] er, input logic [3:0] ef, input int el);
    int w = 0;
    @(negedge clk);
    a = ta; b = tb_v; in_valid = 1'b1;
    while (!in_ready && w < 50) begin @(negedge clk); w++; end
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL accept_wait in_ready=%b required=1", in_ready);
    end
    sb.push_back('{er, ef, el});
    @(posedge clk);
    #1;
  endtask

  // Wait for out_valid, pop the scoreboard and compare result, flags, latency.
  task automatic get_result(input string name, input bit keep_valid);
    int k = 0;
    exp_t e;
    @(negedge clk);
    if (!keep_valid) in_valid = 1'b0;
    while (!out_valid && k < 60) begin @(negedge clk); k++; end
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL %s scoreboard_empty", name);
      return;
    end
    e = sb.pop_front();
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL %s timeout out_valid=%b required=1", name, out_valid);
    end
    total++;
    if (result !== e.res) begin
      bad++;
      $display("FAIL %s result=%h required=%h", name, result, e.res);
    end
    total++;
    if (flags !== e.flg) begin
      bad++;
      $display("FAIL %s flags=%b required=%b", name, flags, e.flg);
    end
    total++;
    if (k != e.lat) begin
      bad++;
      $display("FAIL %s latency=%0d required=%0d", name, k, e.lat);
    end
  endtask

  // Pulse out_ready for one edge; in_ready must be back the next cycle.
  task automatic ack(input string name);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s_ack in_ready=%b out_valid=%b required=1/0", name, in_ready, out_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total++;
    if (out_valid !== 1'b0 || result !== 32'd0 || flags !== 4'd0) begin
      bad++;
      $display("FAIL reset_outputs out_valid=%b result=%h flags=%b required=0", out_valid, result, flags);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_ready in_ready=%b required=1", in_ready);
    end
  endtask

  task automatic test_normal();
    push_op(32'h40C0_0000, 32'hBF00_0000, 32'hC140_0000, 4'b0000, LAT_N);
    get_result("six_div_neg_half", 1'b0); ack("six");
    push_op(32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 4'b0000, LAT_N);
    get_result("one_div_three", 1'b0); ack("third");
    push_op(32'h4040_0000, 32'h3FC0_0000, 32'h4000_0000, 4'b0000, LAT_N);
    get_result("three_div_1p5", 1'b0); ack("two");
  endtask

  task automatic test_specials();
    push_op(32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 4'b0100, LAT_S);
    get_result("one_div_pzero", 1'b0); ack("dz_p");
    push_op(32'h3F80_0000, 32'h8000_0000, 32'hFF80_0000, 4'b0100, LAT_S);
    get_result("one_div_nzero", 1'b0); ack("dz_n");
    push_op(32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 4'b1000, LAT_S);
    get_result("zero_div_zero", 1'b0); ack("nv_zz");
    push_op(32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 4'b1000, LAT_S);
    get_result("inf_div_inf", 1'b0); ack("nv_ii");
    push_op(32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 4'b1000, LAT_S);
    get_result("nan_div_one", 1'b0); ack("nv_nan");
    push_op(32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 4'b0000, LAT_S);
    get_result("ninf_div_two", 1'b0); ack("inf_fin");
    push_op(32'h7F80_0000, 32'h0000_0000, 32'h7F80_0000, 4'b0000, LAT_S);
    get_result("inf_div_zero", 1'b0); ack("inf_zero");
    push_op(32'h3F80_0000, 32'hFF80_0000, 32'h8000_0000, 4'b0000, LAT_S);
    get_result("one_div_ninf", 1'b0); ack("fin_inf");
    push_op(32'h8000_0000, 32'h4000_0000, 32'h8000_0000, 4'b0000, LAT_S);
    get_result("nzero_div_two", 1'b0); ack("zero_fin");
    push_op(32'h8040_0000, 32'h3F80_0000, 32'h8000_0000, 4'b0000, LAT_S);
    get_result("denorm_flush", 1'b0); ack("denorm");
  endtask

  task automatic test_range();
    push_op(32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000, 4'b0010, LAT_N);
    get_result("overflow", 1'b0); ack("of");
    push_op(32'h0080_0000, 32'h4F00_0000, 32'h0000_0000, 4'b0001, LAT_N);
    get_result("underflow", 1'b0); ack("uf");
  endtask

  task automatic test_backpressure();
    push_op(32'h40C0_0000, 32'hBF00_0000, 32'hC140_0000, 4'b0000, LAT_N);
    get_result("bp_result", 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a = $urandom; b = $urandom;
      total++;
      if (result !== 32'hC140_0000 || flags !== 4'b0000 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold cyc=%0d result=%h flags=%b out_valid=%b in_ready=%b required=c1400000/0000/1/0",
                 i, result, flags, out_valid, in_ready);
      end
    end
    ack("bp");
  endtask

  task automatic test_back_to_back();
    push_op(32'h40C0_0000, 32'hBF00_0000, 32'hC140_0000, 4'b0000, LAT_N);
    a = 32'h3F80_0000; b = 32'h4000_0000;
    sb.push_back('{32'h3F00_0000, 4'b0000, LAT_N});
    get_result("b2b_first", 1'b1);
    ack("b2b_first");
    get_result("b2b_second", 1'b0);
    ack("b2b_second");
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        bad++;
        $display("FAIL b2b_no_dup cyc=%0d out_valid=%b in_ready=%b required=0/1", i, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    exp_t dropped;
    push_op(32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 4'b0000, LAT_N);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || result !== 32'd0 || flags !== 4'd0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL mid_wait_reset out_valid=%b result=%h flags=%b in_ready=%b required=0/0/0/1",
               out_valid, result, flags, in_ready);
    end
    dropped = sb.pop_front();
    @(negedge clk);
    rst_n = 1'b1;
    push_op(32'h3F80_0000, 32'h4000_0000, 32'h3F00_0000, 4'b0000, LAT_N);
    get_result("after_reset", 1'b0);
    ack("after_reset");
  endtask

  initial begin
    test_reset();
    test_normal();
    test_specials();
    test_range();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fpu_sp_div_ctrl.md
FPU_SP_DIV_CTRL -- requirements
Module: fpu_sp_div_ctrl

Interface
REQ-001 SHALL have parameter DIV_CYCLES, default 2: number of settle cycles given to the combinational divider datapath (legal range 1..15).
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port in_valid, input, 1: operand pair valid.
REQ-005 SHALL have port in_ready, output, 1: block can accept an operand pair.
REQ-006 SHALL have port a, input, 32: IEEE-754 single-precision dividend.
REQ-007 SHALL have port b, input, 32: IEEE-754 single-precision divisor.
REQ-008 SHALL have port out_valid, output, 1: result and flags valid.
REQ-009 SHALL have port out_ready, input, 1: consumer accepts the result.
REQ-010 SHALL have port result, output, 32: quotient, single precision.
REQ-011 SHALL have port flags, output, 4: {nv, dz, of, uf} = invalid, divide-by-zero, overflow, underflow.

Function
REQ-012 SHALL implement FSM states IDLE, WAIT, DONE.
REQ-013 SHALL assert in_ready only in IDLE; a transfer occurs on an edge where in_valid && in_ready, capturing a and b into operand registers.
REQ-014 SHALL classify captured operands: exponent==0 -> zero (denormals flushed to signed zero), exponent==255 with mantissa==0 -> inf, exponent==255 with mantissa!=0 -> NaN.
REQ-015 SHALL resolve special cases without the divider, with sign = sign_a ^ sign_b unless NaN:
- either NaN, 0/0, inf/inf -> 0x7FC00000, nv=1;
- nonzero finite / 0 -> signed inf, dz=1;
- inf / finite -> signed inf;
- finite / inf -> signed zero;
- 0 / nonzero finite -> signed zero.
REQ-016 On a special-case transfer SHALL go IDLE->DONE; out_valid rises the cycle after the transfer (latency 1).
REQ-017 On a normal transfer SHALL go IDLE->WAIT, load a down-counter with DIV_CYCLES, decrement each cycle, and at count 1 register the divider output and go to DONE; out_valid rises DIV_CYCLES+1 cycles after the transfer.
REQ-018 SHALL set of=1 when normal-path result exponent==255, and uf=1 when normal-path result exponent==0; in the uf case it SHALL force the result to signed zero.
REQ-019 In DONE, result and flags SHALL be held stable until out_ready=1; on out_valid && out_ready the block SHALL return to IDLE, with in_ready=1 the following cycle (no same-cycle accept/return).
REQ-020 Operand inputs SHALL be ignored outside IDLE; the divider SHALL see only the registered operands, never the live ports.
REQ-021 in_valid held high across DONE SHALL be accepted only after the return to IDLE; no transfer is lost or duplicated.

Reset
REQ-022 Asserting rst_n low at any time, including mid-WAIT, SHALL immediately force state=IDLE, counter=0, out_valid=0, result=0x00000000, flags=4'b0000, operand registers=0; any in-flight operation is discarded.
REQ-023 After rst_n deasserts, in_ready SHALL be 1 from the first clock.

Structure
REQ-024 Package fpu_sp_pkg SHALL hold: the FSM state enum, the QNAN (0x7FC00000) and exponent-all-ones constants, flag bit indices, and an operand-class enum (ZERO, NORM, INF, NAN).
REQ-025 SHALL instantiate exactly one sub-module, fpu_sp_divider (ports: dividend, divisor, quotient, all 32-bit, combinational), fed from the operand registers.

Verification
REQ-026 a=0x40C00000 (6.0), b=0xBF000000 (-0.5), DIV_CYCLES=2 -> result=0xC1400000, flags=0000, out_valid exactly 3 cycles after the transfer.
REQ-027 a=0x3F800000, b=0x00000000 -> result=0x7F800000, flags=0100, out_valid 1 cycle after the transfer; b=0x80000000 -> result=0xFF800000.
REQ-028 a=0x00000000, b=0x00000000 and a=0x7F800000, b=0xFF800000 -> result=0x7FC00000, flags=1000.
REQ-029 a=0x7F000000, b=0x3E800000 -> flags of=1; a=0x00800000, b=0x4F000000 -> uf=1, result=0x00000000.
REQ-030 Hold out_ready=0 for 5 cycles in DONE -> result, flags, out_valid unchanged and in_ready=0; then pulse out_ready -> in_ready=1 next cycle.
REQ-031 Drop rst_n during WAIT -> outputs zero asynchronously; the next transfer after reset completes correctly with no trace of the aborted one.
